// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/clear, one-edge latency, en=0 freezes state.
// Optional parity output is built only when USR_PARITY_EN is defined.
module univ_shift_reg #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int                CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sl_in,
  input  logic             sr_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [CW-1:0]    shift_cnt,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             moved;

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    moved  = 1'b0;
    if (en) begin
      case (mode)
        M_LOAD: begin q_d = d;         cnt_d = '0; end
        M_SHL:  begin q_d = {q_q[WIDTH-2:0], sl_in};    moved = 1'b1; end
        M_SHR:  begin q_d = {sr_in, q_q[WIDTH-1:1]};    moved = 1'b1; end
        M_ROL:  begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; moved = 1'b1; end
        M_ROR:  begin q_d = {q_q[0], q_q[WIDTH-1:1]};   moved = 1'b1; end
        M_CLR:  begin q_d = RESET_VAL; cnt_d = '0; end
        default: ;
      endcase
    end
    // Count wraps modulo WIDTH; the wrap itself raises done on the next cycle.
    if (moved) begin
      done_d = (cnt_q == CNT_MAX);
      cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q         = q_q;
  assign qbar      = ~q_q;
  assign shift_cnt = cnt_q;
  assign done      = done_q;

`ifdef USR_PARITY_EN
  assign parity = ^q_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomized and directed bench for univ_shift_reg (WIDTH=8, RESET_VAL=0).
module tb_univ_shift_reg;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] d = 8'h00;
  logic       sl_in = 1'b0;
  logic       sr_in = 1'b0;
  logic [7:0] q, qbar;
  logic [2:0] shift_cnt;
  logic       done;
`ifdef USR_PARITY_EN
  logic       parity;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: register value, shift count and expected done flag.
  logic [7:0] mq = 8'h00;
  int         mcnt = 0;
  logic       mdone = 1'b0;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
    .sl_in(sl_in), .sr_in(sr_in), .q(q), .qbar(qbar),
    .shift_cnt(shift_cnt), .done(done)
`ifdef USR_PARITY_EN
    , .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  // Drive one operation, let one edge pass, advance the reference model.
  task automatic cyc(input logic e, input logic [2:0] m, input logic [7:0] dv,
                     input logic sl, input logic sr);
    logic moved;
    en = e; mode = m; d = dv; sl_in = sl; sr_in = sr;
    @(posedge clk);
    #1;
    moved = 1'b0;
    mdone = 1'b0;
    if (e) begin
      case (m)
        3'd1: begin mq = dv; mcnt = 0; end
        3'd2: begin mq = 8'((mq * 2) + sl); moved = 1'b1; end
        3'd3: begin mq = 8'((mq / 2) + (sr ? 128 : 0)); moved = 1'b1; end
        3'd4: begin mq = 8'((mq * 2) + (mq / 128)); moved = 1'b1; end
        3'd5: begin mq = 8'((mq / 2) + ((mq % 2) * 128)); moved = 1'b1; end
        3'd6: begin mq = 8'h00; mcnt = 0; end
        default: ;
      endcase
    end
    if (moved) begin
      mcnt = mcnt + 1;
      if (mcnt == 8) begin mcnt = 0; mdone = 1'b1; end
    end
  endtask

  task automatic model_reset();
    mq = 8'h00; mcnt = 0; mdone = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q !== 8'h00 || qbar !== 8'hFF || shift_cnt !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: q=%h qbar=%h cnt=%0d done=%b required 00 ff 0 0", q, qbar, shift_cnt, done);
    end
    rst_n = 1'b1;
    // First edge after release executes the sampled operation.
    cyc(1'b1, 3'd1, 8'h5A, 1'b0, 1'b0);
    checks++;
    if (q !== 8'h5A) begin
      errors++;
      $display("FAIL reset_release_load: q=%h required 5a", q);
    end
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_done: done=%b required 1", done);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (q !== 8'h00 || qbar !== 8'hFF || shift_cnt !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: q=%h qbar=%h cnt=%0d done=%b required 00 ff 0 0", q, qbar, shift_cnt, done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rotate();
    cyc(1'b1, 3'd1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
      if (i < 7) begin
        checks++;
        if (done !== 1'b0 || shift_cnt !== 3'(i + 1)) begin
          errors++;
          $display("FAIL rotate_step%0d: done=%b cnt=%0d required 0 %0d", i, done, shift_cnt, i + 1);
        end
      end
    end
    checks++;
    if (q !== 8'hA5 || done !== 1'b1 || shift_cnt !== 3'd0) begin
      errors++;
      $display("FAIL rotate8: q=%h done=%b cnt=%0d required a5 1 0", q, done, shift_cnt);
    end
    cyc(1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b0 || q !== 8'hA5) begin
      errors++;
      $display("FAIL rotate_done_once: done=%b q=%h required 0 a5", done, q);
    end
    cyc(1'b1, 3'd1, 8'h96, 1'b0, 1'b0);
    cyc(1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
    checks++;
    if (q !== 8'h4B) begin
      errors++;
      $display("FAIL rotate_right: q=%h required 4b", q);
    end
  endtask

  task automatic test_shift();
    cyc(1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
    checks++;
    if (q !== 8'h03 || qbar !== 8'hFC) begin
      errors++;
      $display("FAIL shift_left: q=%h qbar=%h required 03 fc", q, qbar);
    end
    cyc(1'b1, 3'd3, 8'h00, 1'b1, 1'b0);
    checks++;
    if (q !== 8'h01) begin
      errors++;
      $display("FAIL shift_right: q=%h required 01", q);
    end
    cyc(1'b1, 3'd3, 8'h00, 1'b0, 1'b1);
    checks++;
    if (q !== 8'h80) begin
      errors++;
      $display("FAIL shift_right_srin: q=%h required 80", q);
    end
  endtask

  task automatic test_enable();
    cyc(1'b1, 3'd1, 8'h0F, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 3'd2, 8'hFF, 1'b1, 1'b1);
      checks++;
      if (q !== 8'h78 || shift_cnt !== 3'd3 || done !== 1'b0) begin
        errors++;
        $display("FAIL enable_hold%0d: q=%h cnt=%0d done=%b required 78 3 0", i, q, shift_cnt, done);
      end
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
      if (i < 4) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL enable_early_done%0d: done=%b required 0", i, done);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || shift_cnt !== 3'd0 || q !== 8'h00) begin
      errors++;
      $display("FAIL enable_done: done=%b cnt=%0d q=%h required 1 0 00", done, shift_cnt, q);
    end
  endtask

  task automatic test_load_abort();
    for (int i = 0; i < 7; i++) cyc(1'b1, 3'd2, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
    checks++;
    if (shift_cnt !== 3'd7) begin
      errors++;
      $display("FAIL abort_pre_cnt: cnt=%0d required 7", shift_cnt);
    end
    cyc(1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
    checks++;
    if (q !== 8'h3C || shift_cnt !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_load: q=%h cnt=%0d done=%b required 3c 0 0", q, shift_cnt, done);
    end
    cyc(1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
    checks++;
    if (q !== 8'h3C || done !== 1'b0 || shift_cnt !== 3'd0) begin
      errors++;
      $display("FAIL abort_reserved: q=%h done=%b cnt=%0d required 3c 0 0", q, done, shift_cnt);
    end
    cyc(1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
    checks++;
    if (q !== 8'h00 || qbar !== 8'hFF) begin
      errors++;
      $display("FAIL clear: q=%h qbar=%h required 00 ff", q, qbar);
    end
  endtask

  task automatic test_reset_midseq();
    cyc(1'b1, 3'd1, 8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    model_reset();
    cyc(1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
    checks++;
    if (done !== 1'b0 || shift_cnt !== 3'd1 || q !== 8'h01) begin
      errors++;
      $display("FAIL reset_midseq: done=%b cnt=%0d q=%h required 0 1 01", done, shift_cnt, q);
    end
  endtask

  task automatic test_random();
    logic [2:0] m;
    for (int i = 0; i < 400; i++) begin
      m = 3'($urandom_range(0, 7));
      // Bias toward shifts/rotates so the count wraps often.
      if ($urandom_range(0, 3) != 0) m = 3'($urandom_range(2, 5));
      cyc(1'($urandom_range(0, 7) != 0), m, 8'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (q !== mq || qbar !== ~mq || shift_cnt !== 3'(mcnt) || done !== mdone) begin
        errors++;
        $display("FAIL random%0d: q=%h qbar=%h cnt=%0d done=%b required %h %h %0d %b",
                 i, q, qbar, shift_cnt, done, mq, ~mq, mcnt, mdone);
      end
`ifdef USR_PARITY_EN
      checks++;
      if (parity !== ^mq) begin
        errors++;
        $display("FAIL random_parity%0d: parity=%b required %b", i, parity, ^mq);
      end
`endif
    end
  endtask

`ifdef USR_PARITY_EN
  task automatic test_parity();
    cyc(1'b1, 3'd1, 8'h07, 1'b0, 1'b0);
    checks++;
    if (parity !== 1'b1) begin
      errors++;
      $display("FAIL parity_07: parity=%b required 1", parity);
    end
    cyc(1'b1, 3'd1, 8'h03, 1'b0, 1'b0);
    checks++;
    if (parity !== 1'b0) begin
      errors++;
      $display("FAIL parity_03: parity=%b required 0", parity);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rotate();
    test_shift();
    test_enable();
    test_load_abort();
    test_reset_midseq();
`ifdef USR_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into q on reset and on clear.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port en  input  1  operation enable; 0 forces hold.
REQ-006 SHALL have port mode  input  3  operation select (REQ-013).
REQ-007 SHALL have port d  input  WIDTH  parallel load data.
REQ-008 SHALL have port sl_in  input  1  serial input entering bit 0 on shift-left.
REQ-009 SHALL have port sr_in  input  1  serial input entering bit WIDTH-1 on shift-right.
REQ-010 SHALL have ports q and qbar  output  WIDTH  register contents and their bitwise complement; qbar == ~q at all times.
REQ-011 SHALL have port shift_cnt  output  CW  count of shift/rotate operations since the last load or clear, modulo WIDTH; CW = clog2(WIDTH).
REQ-012 SHALL have port done  output  1  registered one-cycle pulse marking completion of WIDTH shifts.

Function
REQ-013 SHALL decode mode when en=1: 000 hold; 001 load q<=d; 010 shift-left q<={q[W-2:0],sl_in}; 011 shift-right q<={sr_in,q[W-1:1]}; 100 rotate-left; 101 rotate-right; 110 clear q<=RESET_VAL; 111 hold (reserved).
REQ-014 SHALL update q exactly one clock edge after the sampled operation; no combinational path from d, sl_in or sr_in to q.
REQ-015 SHALL hold q and shift_cnt and drive done=0 on every edge where en=0, regardless of mode.
REQ-016 SHALL increment shift_cnt on each enabled shift or rotate, wrapping from WIDTH-1 to 0.
REQ-017 SHALL assert done for exactly the one cycle following the edge at which shift_cnt wraps from WIDTH-1 to 0, and deassert it otherwise.
REQ-018 SHALL clear shift_cnt to 0 on load or clear, and SHALL NOT assert done on that edge, even if shift_cnt was WIDTH-1.
REQ-019 SHALL leave shift_cnt unchanged on hold or reserved modes.
REQ-020 SHALL NOT decode any mode as a bit-0 or bit-(WIDTH-1) only shift; all WIDTH bits move on every shift or rotate.

Reset
REQ-021 SHALL, while rst_n=0, immediately drive q=RESET_VAL, qbar=~RESET_VAL, shift_cnt=0 and done=0, independent of clk.
REQ-022 SHALL release reset synchronously to normal operation; the first edge with rst_n=1 executes the sampled mode.
REQ-023 SHALL abandon any in-progress shift sequence on reset mid-operation; no done pulse results from the interrupted count.

Configuration
REQ-024 SHALL, when macro USR_PARITY_EN is defined, add output port parity (1 bit) equal to the XOR reduction of q, combinational from q only.
REQ-025 SHALL, when USR_PARITY_EN is undefined, omit the parity port and logic entirely; all other behaviour is identical.

Verification (WIDTH=8, RESET_VAL=0)
REQ-026 SHALL cover: rst_n=0 asynchronously mid-cycle -> q=0x00, qbar=0xFF, shift_cnt=0, done=0 before next clk edge.
REQ-027 SHALL cover: load d=0xA5, then 8 rotate-left -> q=0xA5 after 8th shift, done=1 for one cycle only, shift_cnt=0.
REQ-028 SHALL cover: load 0x81, shift-left sl_in=1 -> q=0x03; then shift-right sr_in=0 -> q=0x01.
REQ-029 SHALL cover: load 0x0F, 3 shift-left, en=0 for 5 cycles with mode=010, 5 more shift-left -> q frozen and shift_cnt=3 during en=0; done pulses after the 8th enabled shift.
REQ-030 SHALL cover: 7 shifts then load 0x3C -> shift_cnt=0, no done pulse, q=0x3C; clear -> q=0x00.
REQ-031 SHALL cover with USR_PARITY_EN defined: load 0x07 -> parity=1; load 0x03 -> parity=0.
